wb_sequencer: RTL and testbench

Writeback sequencer that drives the 8x8 register file's single write port and its conditional-bit port. It accepts results from the ALU (buffered in a small FIFO) and from the load path (single holding register), arbitrates between them with load priority, and emits at most one register write per cycle. It also keeps a per-register pending-write scoreboard, so decode can stall an issue whose destination register still has an outstanding write.

---
 rtl/wb_sequencer_if.sv | 47 ++++
 rtl/wb_sequencer.sv | 135 +++++++++++++
 tb/tb_wb_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// Writeback sequencer bus: decode issue, ALU and load producers,
// and the register-file write / conditional-bit ports.
interface wb_sequencer_if;
    logic       issue_i;
    logic [2:0] issue_addr_i;
    logic       issue_stall_o;
    logic [7:0] busy_o;
    logic       alu_valid_i;
    logic       alu_ready_o;
    logic [2:0] alu_addr_i;
    logic [7:0] alu_data_i;
    logic       alu_cb_valid_i;
    logic       alu_cb_i;
    logic       mem_valid_i;
    logic       mem_ready_o;
    logic [2:0] mem_addr_i;
    logic [7:0] mem_data_i;
    logic       write_o;
    logic [2:0] write_addr_o;
    logic [7:0] write_data_o;
    logic       write_cb_o;
    logic       cb_data_o;

    modport slave (
        input  issue_i, issue_addr_i,
        output issue_stall_o, busy_o,
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  alu_cb_valid_i, alu_cb_i,
        output alu_ready_o,
        input  mem_valid_i, mem_addr_i, mem_data_i,
        output mem_ready_o,
        output write_o, write_addr_o, write_data_o,
        output write_cb_o, cb_data_o
    );

    modport master (
        output issue_i, issue_addr_i,
        input  issue_stall_o, busy_o,
        output alu_valid_i, alu_addr_i, alu_data_i,
        output alu_cb_valid_i, alu_cb_i,
        input  alu_ready_o,
        output mem_valid_i, mem_addr_i, mem_data_i,
        input  mem_ready_o,
        input  write_o, write_addr_o, write_data_o,
        input  write_cb_o, cb_data_o
    );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: ALU FIFO plus load holding register, load-first
// arbitration onto the register-file write port, and a pending-write scoreboard.
module wb_sequencer #(
    parameter int DEPTH = 4
) (
    input logic          clk_i,
    input logic          reset_i,
    wb_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
        logic       cb_valid;
        logic       cb;
    } entry_t;

    entry_t         fifo_q [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           hold_valid;
    logic [2:0]     hold_addr;
    logic [7:0]     hold_data;
    logic [7:0]     busy;

    logic           full;
    logic           empty;
    logic           push;
    logic           capture;
    logic           pop;
    logic           issue_ok;
    logic [7:0]     set_mask;
    logic [7:0]     clr_mask;
    entry_t         head;
    entry_t         in_entry;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign bus.alu_ready_o   = !reset_i && !full;
    assign bus.mem_ready_o   = !reset_i && !hold_valid;
    assign bus.issue_stall_o = !reset_i && bus.issue_i && busy[bus.issue_addr_i];
    assign bus.busy_o        = busy;

    assign push     = bus.alu_valid_i && bus.alu_ready_o;
    assign capture  = bus.mem_valid_i && bus.mem_ready_o;
    // The holding register always wins; the FIFO only drains behind it.
    assign pop      = !hold_valid && !empty;
    assign head     = fifo_q[rd_ptr];
    assign issue_ok = !reset_i && bus.issue_i && !busy[bus.issue_addr_i];

    assign in_entry = '{
        addr:     bus.alu_addr_i,
        data:     bus.alu_data_i,
        cb_valid: bus.alu_cb_valid_i,
        cb:       bus.alu_cb_i
    };

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_ok) begin
            set_mask = 8'b1 << bus.issue_addr_i;
        end
        unique case (1'b1)
            hold_valid: clr_mask = 8'b1 << hold_addr;
            pop:        clr_mask = 8'b1 << head.addr;
            default:    clr_mask = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            fifo_q[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            hold_valid       <= 1'b0;
            hold_addr        <= '0;
            hold_data        <= '0;
            busy             <= '0;
            bus.write_o      <= 1'b0;
            bus.write_addr_o <= '0;
            bus.write_data_o <= '0;
            bus.write_cb_o   <= 1'b0;
            bus.cb_data_o    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            if (capture) begin
                hold_valid <= 1'b1;
                hold_addr  <= bus.mem_addr_i;
                hold_data  <= bus.mem_data_i;
            end else if (hold_valid) begin
                hold_valid <= 1'b0;
            end

            busy <= (busy & ~clr_mask) | set_mask;

            unique case (1'b1)
                hold_valid: begin
                    bus.write_o      <= 1'b1;
                    bus.write_addr_o <= hold_addr;
                    bus.write_data_o <= hold_data;
                    bus.write_cb_o   <= 1'b0;
                end
                pop: begin
                    bus.write_o      <= 1'b1;
                    bus.write_addr_o <= head.addr;
                    bus.write_data_o <= head.data;
                    bus.write_cb_o   <= head.cb_valid;
                    bus.cb_data_o    <= head.cb;
                end
                default: begin
                    bus.write_o    <= 1'b0;
                    bus.write_cb_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sequencer.sv
// Randomized scoreboard bench for wb_sequencer against a queue-based
// reference model of the writeback ordering and pending-write bits.
module tb_wb_sequencer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        logic       cbv;
        logic       cb;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    wb_sequencer_if bus();

    wb_sequencer #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 0;
    bit   full_seen = 0;

    ent_t       m_q[$];
    ent_t       m_hold;
    bit         m_hold_v = 0;
    logic [7:0] m_busy = '0;
    ent_t       exp_q[$];
    bit         acc_alu, acc_mem, acc_iss;
    int         owed[$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.issue_i        = 0;
        bus.issue_addr_i   = 0;
        bus.alu_valid_i    = 0;
        bus.alu_addr_i     = 0;
        bus.alu_data_i     = 0;
        bus.alu_cb_valid_i = 0;
        bus.alu_cb_i       = 0;
        bus.mem_valid_i    = 0;
        bus.mem_addr_i     = 0;
        bus.mem_data_i     = 0;
    endtask

    // Reference: loads first, then ALU results in arrival order.
    task automatic model_step();
        ent_t e;
        bit   have;
        int   sz;
        acc_alu = 0;
        acc_mem = 0;
        acc_iss = 0;
        if (reset) begin
            m_q.delete();
            m_hold_v = 0;
            m_busy = '0;
            return;
        end
        sz = m_q.size();
        acc_alu = bus.alu_valid_i && (sz < DEPTH);
        acc_mem = bus.mem_valid_i && !m_hold_v;
        acc_iss = bus.issue_i && !m_busy[bus.issue_addr_i];
        have = 0;
        if (m_hold_v) begin
            e = m_hold;
            m_hold_v = 0;
            have = 1;
        end else if (sz != 0) begin
            e = m_q.pop_front();
            have = 1;
        end
        if (have) begin
            exp_q.push_back(e);
            m_busy[e.a] = 1'b0;
        end
        if (acc_iss) m_busy[bus.issue_addr_i] = 1'b1;
        if (acc_alu) m_q.push_back('{bus.alu_addr_i, bus.alu_data_i,
                                     bus.alu_cb_valid_i, bus.alu_cb_i});
        if (acc_mem) begin
            m_hold = '{bus.mem_addr_i, bus.mem_data_i, 1'b0, 1'b0};
            m_hold_v = 1;
        end
    endtask

    // Inputs are set between negedge+1 and the next posedge.
    task automatic tick();
        #1;
        if (bus.issue_i && !reset)
            chk("issue_stall", bus.issue_stall_o, m_busy[bus.issue_addr_i]);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic owed_remove(input int r);
        foreach (owed[i]) begin
            if (owed[i] == r) begin
                owed.delete(i);
                return;
            end
        end
    endtask

    initial begin : monitor
        ent_t e;
        bit   want;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                want = exp_q.size() != 0;
                chk("write_o", bus.write_o, want);
                if (want) begin
                    e = exp_q.pop_front();
                    if (bus.write_o) begin
                        chk("write_addr", bus.write_addr_o, e.a);
                        chk("write_data", bus.write_data_o, e.d);
                        chk("write_cb", bus.write_cb_o, e.cbv);
                        if (e.cbv) chk("cb_data", bus.cb_data_o, e.cb);
                    end
                end
                chk("busy", bus.busy_o, m_busy);
                chk("alu_ready", bus.alu_ready_o, !reset && m_q.size() < DEPTH);
                chk("mem_ready", bus.mem_ready_o, !reset && !m_hold_v);
                if (!reset && m_q.size() == DEPTH) full_seen = 1;
            end
        end
    end

    initial begin : driver
        int         aa, ma, ia;
        logic [7:0] dv;
        idle_inputs();
        @(negedge clk);
        #1;
        reset = 1;
        tick();
        mon_en = 1;
        tick();
        reset = 0;
        chk("rst_write_addr", bus.write_addr_o, 0);
        chk("rst_write_data", bus.write_data_o, 0);
        chk("rst_cb_data", bus.cb_data_o, 0);
        chk("rst_write_cb", bus.write_cb_o, 0);

        // Single ALU result with conditional bit.
        bus.issue_i = 1; bus.issue_addr_i = 3;
        tick();
        bus.alu_valid_i = 1; bus.alu_addr_i = 3; bus.alu_data_i = 8'hA5;
        bus.alu_cb_valid_i = 1; bus.alu_cb_i = 1;
        tick();
        repeat (3) tick();

        // Load priority over a simultaneously accepted ALU result.
        bus.issue_i = 1; bus.issue_addr_i = 1;
        tick();
        bus.issue_i = 1; bus.issue_addr_i = 2;
        tick();
        bus.alu_valid_i = 1; bus.alu_addr_i = 2; bus.alu_data_i = 8'h33;
        bus.mem_valid_i = 1; bus.mem_addr_i = 1; bus.mem_data_i = 8'h77;
        tick();
        repeat (3) tick();

        // Stall while r5 is pending, then re-issue after its write.
        bus.issue_i = 1; bus.issue_addr_i = 5;
        tick();
        bus.issue_i = 1; bus.issue_addr_i = 5;
        tick();
        bus.alu_valid_i = 1; bus.alu_addr_i = 5; bus.alu_data_i = 8'h55;
        bus.issue_i = 1; bus.issue_addr_i = 5;
        tick();
        repeat (3) begin
            bus.issue_i = 1; bus.issue_addr_i = 5;
            tick();
        end
        bus.alu_valid_i = 1; bus.alu_addr_i = 5; bus.alu_data_i = 8'h56;
        tick();
        repeat (3) tick();

        // Fill the FIFO behind a continuous load stream.
        dv = 8'h10;
        for (int c = 0; c < 16; c++) begin
            if (dv <= 8'h17) begin
                bus.alu_valid_i = 1;
                bus.alu_addr_i = dv[2:0];
                bus.alu_data_i = dv;
            end
            bus.mem_valid_i = 1; bus.mem_addr_i = 7;
            bus.mem_data_i = 8'h80 + 8'(c);
            tick();
            if (acc_alu) dv = dv + 8'h01;
        end
        repeat (10) tick();
        chk("fifo_full_seen", full_seen, 1);

        // Reset with results queued and registers pending.
        for (int r = 0; r < 3; r++) begin
            bus.issue_i = 1; bus.issue_addr_i = 3'(r);
            tick();
        end
        bus.alu_valid_i = 1; bus.alu_addr_i = 0; bus.alu_data_i = 8'hC0;
        bus.mem_valid_i = 1; bus.mem_addr_i = 1; bus.mem_data_i = 8'hC1;
        tick();
        bus.alu_valid_i = 1; bus.alu_addr_i = 2; bus.alu_data_i = 8'hC2;
        tick();
        reset = 1;
        tick();
        reset = 0;
        repeat (6) tick();
        chk("post_reset_busy", bus.busy_o, 0);

        // Randomized traffic honouring the one-pending-write contract.
        for (int c = 0; c < 3000; c++) begin
            int ai;
            int mi;
            ai = -1; mi = -1; aa = 0; ma = 0;
            ia = $urandom_range(0, 7);
            bus.issue_i = 1'($urandom_range(0, 1));
            bus.issue_addr_i = 3'(ia);
            if (owed.size() > 0 && $urandom_range(0, 2) != 0) begin
                ai = $urandom_range(0, owed.size() - 1);
                aa = owed[ai];
                bus.alu_valid_i = 1;
                bus.alu_addr_i = 3'(aa);
                bus.alu_data_i = 8'($urandom);
                bus.alu_cb_valid_i = 1'($urandom_range(0, 1));
                bus.alu_cb_i = 1'($urandom_range(0, 1));
            end
            if (owed.size() > 0 && $urandom_range(0, 1) != 0) begin
                mi = $urandom_range(0, owed.size() - 1);
                if (mi != ai) begin
                    ma = owed[mi];
                    bus.mem_valid_i = 1;
                    bus.mem_addr_i = 3'(ma);
                    bus.mem_data_i = 8'($urandom);
                end
            end
            tick();
            if (acc_alu) owed_remove(aa);
            if (acc_mem) owed_remove(ma);
            if (acc_iss) owed.push_back(ia);
        end
        repeat (12) tick();
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
